// File: rtl/mano_program_loader_pkg.sv
// mano_program_loader_pkg: shared state encoding, error codes and default frame marker
package mano_program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/mano_prog_ram.sv
// mano_prog_ram: DEPTH x 8 program store, one write port, one registered read-before-write port
module mano_prog_ram #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [7:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [7:0]               rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    // contents are never reset so a reset mid-load keeps what was already written
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // read samples the array before this edge's write lands, giving old data on a collision
    always_comb begin
        rdata_d = mem[raddr];
    end

    // registered read port
    always_ff @(posedge clk) begin
        rdata_q <= rst ? 8'h00 : rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mano_program_loader.sv
// mano_program_loader: serial framed program loader with checksum into a CPU-readable RAM
module mano_program_loader
    import mano_program_loader_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic                     err_clr,
    input  logic [$clog2(DEPTH)-1:0] cpu_addr,
    output logic [7:0]               cpu_rdata,
    output logic                     loaded,
    output logic                     busy,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam int AW = $clog2(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [8:0]    len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic          loaded_q, loaded_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          fire;
    logic          we;

    // frame parser: sync, length, data, checksum; errors park in ERR until cleared
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        csum_d     = csum_q;
        loaded_d   = loaded_q;
        err_code_d = err_code_q;
        we         = 1'b0;
        byte_ready = state_q != S_ERR;
        fire       = byte_valid && byte_ready;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (fire && byte_in == SYNC_BYTE) begin
                    state_d  = S_LEN;
                    loaded_d = 1'b0;
                    csum_d   = 8'h00;
                end
            end
            S_LEN: begin
                if (fire) begin
                    if (byte_in == 8'h00 || 9'(byte_in) > 9'(DEPTH)) begin
                        state_d    = S_ERR;
                        err_code_d = ERR_LEN;
                    end else begin
                        state_d = S_DATA;
                        len_d   = 9'(byte_in);
                        ptr_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    we      = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    csum_d  = csum_q + byte_in;
                    state_d = (9'(ptr_q) + 9'd1 == len_q) ? S_CSUM : S_DATA;
                end
            end
            S_CSUM: begin
                if (fire) begin
                    if (byte_in == csum_q) begin
                        state_d  = S_DONE;
                        loaded_d = 1'b1;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_d    = S_IDLE;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            loaded_q   <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            loaded_q   <= loaded_d;
            err_code_q <= err_code_d;
        end
    end

    mano_prog_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (ptr_q),
        .wdata (byte_in),
        .raddr (cpu_addr),
        .rdata (cpu_rdata)
    );

    assign loaded   = loaded_q;
    assign busy     = state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM;
    assign err      = state_q == S_ERR;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_mano_program_loader.sv
// tb_mano_program_loader: directed frames with a read-data scoreboard for mano_program_loader
module tb_mano_program_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       err_clr = 1'b0;
    logic [3:0] cpu_addr = 4'h0;
    logic [7:0] cpu_rdata;
    logic       loaded;
    logic       busy;
    logic       err;
    logic [1:0] err_code;

    int         total = 0;
    int         bad = 0;
    logic [7:0] mdl [16];
    logic [7:0] exp_q [$];

    mano_program_loader #(.DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .err_clr    (err_clr),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .loaded     (loaded),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b, input int a);
        send(b);
        mdl[a] = b;
    endtask

    task automatic rd(input string tag, input logic [3:0] a);
        exp_q.push_back(mdl[a]);
        cpu_addr = a;
        @(posedge clk);
        #1;
        chk(tag, cpu_rdata, exp_q.pop_front());
    endtask

    task automatic clear_err;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        // reset, with a sync byte presented during reset that must be ignored
        rst = 1'b1;
        byte_in = 8'hA5;
        byte_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        byte_valid = 1'b0;
        chk("rst_loaded", {7'd0, loaded}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        chk("rst_code", {6'd0, err_code}, 8'd0);
        chk("rst_ready", {7'd0, byte_ready}, 8'd1);
        chk("rst_rdata", cpu_rdata, 8'h00);

        // noise before sync is dropped, then a good 3-byte frame
        send(8'h00);
        send(8'hFF);
        chk("noise_busy", {7'd0, busy}, 8'd0);
        send(8'hA5);
        chk("sync_busy", {7'd0, busy}, 8'd1);
        send(8'h03);
        send_data(8'h11, 0);
        send_data(8'h22, 1);
        send_data(8'h33, 2);
        chk("csum_busy", {7'd0, busy}, 8'd1);
        chk("pre_loaded", {7'd0, loaded}, 8'd0);
        send(8'h66);
        chk("ok_loaded", {7'd0, loaded}, 8'd1);
        chk("ok_busy", {7'd0, busy}, 8'd0);
        rd("ok_rd0", 4'd0);
        rd("ok_rd1", 4'd1);
        rd("ok_rd2", 4'd2);
        chk("ok_loaded_hold", {7'd0, loaded}, 8'd1);

        // bad checksum
        send(8'hA5);
        chk("resync_loaded", {7'd0, loaded}, 8'd0);
        send(8'h02);
        send_data(8'h10, 0);
        send_data(8'h20, 1);
        send(8'h31);
        chk("cs_err", {7'd0, err}, 8'd1);
        chk("cs_code", {6'd0, err_code}, 8'd2);
        chk("cs_ready", {7'd0, byte_ready}, 8'd0);
        chk("cs_loaded", {7'd0, loaded}, 8'd0);
        send(8'hA5);
        chk("cs_stuck", {7'd0, err}, 8'd1);
        clear_err();
        chk("clr_err", {7'd0, err}, 8'd0);
        chk("clr_code", {6'd0, err_code}, 8'd0);
        chk("clr_ready", {7'd0, byte_ready}, 8'd1);

        // zero length and oversize length
        send(8'hA5);
        send(8'h00);
        chk("len0_err", {7'd0, err}, 8'd1);
        chk("len0_code", {6'd0, err_code}, 8'd1);
        clear_err();
        send(8'hA5);
        send(8'h11);
        chk("len17_code", {6'd0, err_code}, 8'd1);
        rd("len17_rd0", 4'd0);
        rd("len17_rd2", 4'd2);
        clear_err();

        // full-depth length is legal
        send(8'hA5);
        send(8'h10);
        chk("len16_busy", {7'd0, busy}, 8'd1);
        chk("len16_err", {7'd0, err}, 8'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset mid-frame keeps partial words
        send(8'hA5);
        send(8'h04);
        send_data(8'hAA, 0);
        send_data(8'hBB, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_busy", {7'd0, busy}, 8'd0);
        chk("mid_loaded", {7'd0, loaded}, 8'd0);
        rd("mid_rd0", 4'd0);
        rd("mid_rd1", 4'd1);
        rd("mid_rd2", 4'd2);

        // stall mid-frame, then seed address 5
        send(8'hA5);
        send(8'h06);
        for (int i = 0; i < 5; i++) begin
            send_data(8'h00, i);
            repeat (3) @(posedge clk);
            #1;
        end
        chk("stall_busy", {7'd0, busy}, 8'd1);
        send_data(8'h5C, 5);
        send(8'h5C);
        chk("seed_loaded", {7'd0, loaded}, 8'd1);

        // read-before-write collision on address 5
        cpu_addr = 4'd5;
        send(8'hA5);
        send(8'h06);
        for (int i = 0; i < 5; i++) send_data(8'(i + 1), i);
        exp_q.push_back(mdl[5]);
        send_data(8'hC3, 5);
        exp_q.push_back(mdl[5]);
        chk("rbw_old", cpu_rdata, exp_q.pop_front());
        @(posedge clk);
        #1;
        chk("rbw_new", cpu_rdata, exp_q.pop_front());
        send(8'hD2);
        chk("rbw_loaded", {7'd0, loaded}, 8'd1);
        rd("rbw_rd4", 4'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mano_program_loader.md
MANO_PROGRAM_LOADER -- requirements
Module: mano_program_loader

Interface
REQ-001 Parameter: DEPTH, 16, program memory words (power of two, 2..256).
REQ-002 Parameter: SYNC_BYTE, 8'hA5, frame start marker.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: byte_in  input  8  serial load byte.
REQ-006 Port: byte_valid  input  1  byte_in holds a valid byte.
REQ-007 Port: byte_ready  output  1  loader accepts byte this cycle.
REQ-008 Port: err_clr  input  1  single-cycle pulse; leaves ERR.
REQ-009 Port: cpu_addr  input  log2(DEPTH)  CPU read address (MAR).
REQ-010 Port: cpu_rdata  output  8  registered read data (feeds MBR).
REQ-011 Port: loaded  output  1  a complete, checksum-valid program is resident.
REQ-012 Port: busy  output  1  frame in progress (states LEN, DATA, CSUM).
REQ-013 Port: err  output  1  loader in ERR state.
REQ-014 Port: err_code  output  2  00 none, 01 bad length, 10 checksum mismatch.

Function
REQ-015 Byte transfer occurs exactly in cycles where byte_valid and byte_ready are both high; byte_in sampled that edge.
REQ-016 byte_ready is high in IDLE, LEN, DATA, CSUM, DONE; low in ERR.
REQ-017 States: IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-018 IDLE/DONE: accepted byte == SYNC_BYTE -> LEN, clears loaded and checksum; any other byte dropped, state unchanged.
REQ-019 LEN: accepted byte N with 1 <= N <= DEPTH -> DATA, store N, write pointer = 0; N = 0 or N > DEPTH -> ERR, err_code 01.
REQ-020 DATA: each accepted byte written to mem[ptr] same edge, ptr += 1, checksum += byte mod 256; after Nth byte -> CSUM.
REQ-021 CSUM: accepted byte == checksum -> DONE, loaded high next cycle; mismatch -> ERR, err_code 10.
REQ-022 ERR: err_clr -> IDLE, err_code 00; err_clr in any other state ignored.
REQ-023 Words at addresses >= N keep prior contents (no zero-fill).
REQ-024 cpu_rdata = mem[cpu_addr] registered, 1-cycle latency, readable in every state.
REQ-025 Same-cycle write and read of one address returns old data (read-before-write).
REQ-026 loaded stays high through DONE until the next accepted SYNC_BYTE.
REQ-027 byte_valid low mid-frame: FSM waits indefinitely, no timeout.

Reset
REQ-028 rst: state IDLE, ptr 0, checksum 0, stored N 0, loaded 0, err_code 00, cpu_rdata 0.
REQ-029 Memory contents not reset; rst mid-frame abandons frame, partially written words remain.
REQ-030 rst dominates byte_valid, err_clr same cycle.

Structure
REQ-031 Shared package holds state encoding, err_code constants, default SYNC_BYTE.
REQ-032 One sub-module: mano_prog_ram (DEPTH x 8, one write port, one registered read port).

Verification
REQ-033 Frame A5,03,11,22,33,66 -> DONE, loaded=1; cpu_addr 0/1/2 -> 11/22/33 one cycle later.
REQ-034 Frame A5,02,10,20,31 -> ERR, err_code 10, byte_ready 0, loaded 0; err_clr -> IDLE, err_code 00.
REQ-035 A5,00 -> ERR code 01; A5,11 (DEPTH 16) -> ERR code 01, memory unchanged.
REQ-036 Bytes 00,FF before A5 dropped; following valid frame loads normally.
REQ-037 rst after 2 of 4 data bytes -> IDLE, loaded 0; those 2 words readable at addr 0,1.
REQ-038 Write to addr 5 while cpu_addr=5 -> old value next cycle, new value the cycle after.
